// File: rtl/mudi_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// type and small elaboration-time helpers. The instruction decoder imports
// the same op constants so both sides agree on the encoding.
package mudi_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mudiState;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic opIsDiv(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mudi_unit_if.sv
// Request/result bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface mudi_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mudi_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is
// computed combinationally on the start edge and parked in pending
// registers; the FSM then models the latency and commits after N cycles.
module mudi_unit
  import mudi_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic         clk,
  input logic         rst_n,
  mudi_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(maxInt(MULT_CYC, DIV_CYC)) + 1;

  mudiState             state, stateNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic                 loadPend, commit, writeHi, writeLo;
  logic                 doneReg;
  logic [WIDTH-1:0]     hiReg, loReg;
  logic [WIDTH-1:0]     pendHi, pendLo;
  logic                 pendWrite;

  logic [2*WIDTH-1:0]   mulA, mulB, product;
  logic                 isDiv, signedDiv, negA, negB;
  logic [WIDTH-1:0]     magA, magB, safeB, qMag, rMag, quot, rem;
  logic [WIDTH-1:0]     resHi, resLo;

  // Arithmetic on the live operands; only sampled on a valid start.
  always_comb begin
    isDiv     = opIsDiv(bus.op);
    signedDiv = (bus.op == OP_DIV);
    // Extending to 2*WIDTH makes the truncated product correct for both
    // signed and unsigned interpretations.
    if (bus.op == OP_MULT) begin
      mulA = {{WIDTH{bus.rs_val[WIDTH-1]}}, bus.rs_val};
      mulB = {{WIDTH{bus.rt_val[WIDTH-1]}}, bus.rt_val};
    end else begin
      mulA = {{WIDTH{1'b0}}, bus.rs_val};
      mulB = {{WIDTH{1'b0}}, bus.rt_val};
    end
    product = mulA * mulB;

    // Signed division via magnitudes: quotient truncates toward zero and
    // the remainder takes the dividend's sign. The most-negative / -1 case
    // wraps back to the most-negative value with a zero remainder.
    negA  = signedDiv & bus.rs_val[WIDTH-1];
    negB  = signedDiv & bus.rt_val[WIDTH-1];
    magA  = negA ? -bus.rs_val : bus.rs_val;
    magB  = negB ? -bus.rt_val : bus.rt_val;
    safeB = (magB == '0) ? WIDTH'(1) : magB;
    qMag  = magA / safeB;
    rMag  = magA % safeB;
    quot  = (negA ^ negB) ? -qMag : qMag;
    rem   = negA ? -rMag : rMag;

    resHi = isDiv ? rem  : product[2*WIDTH-1:WIDTH];
    resLo = isDiv ? quot : product[WIDTH-1:0];
  end

  // Next-state, counter and write-enable decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    stateNext = state;
    cntNext   = cnt;
    loadPend  = 1'b0;
    commit    = 1'b0;
    writeHi   = 1'b0;
    writeLo   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              stateNext = ST_BUSY;
              cntNext   = CNT_W'(MULT_CYC);
              loadPend  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              stateNext = ST_BUSY;
              cntNext   = CNT_W'(DIV_CYC);
              loadPend  = 1'b1;
            end
            OP_MTHI: writeHi = 1'b1;
            OP_MTLO: writeLo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (bus.flush) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
        end else if (cnt == CNT_W'(1)) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
          commit    = 1'b1;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: begin
        stateNext = ST_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // FSM state, latency counter and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      doneReg <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values
      // from before this edge, independent of statement order.
      state   <= stateNext;
      cnt     <= cntNext;
      doneReg <= commit;
    end
  end

  // Pending result capture and HI/LO updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the pending registers are reset as well, so a reset can
      // never leave a stale result waiting to be committed.
      pendHi    <= '0;
      pendLo    <= '0;
      pendWrite <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
    end else begin
      if (loadPend) begin
        pendHi    <= resHi;
        pendLo    <= resLo;
        pendWrite <= !(isDiv && (bus.rt_val == '0));
      end
      if (commit) begin
        if (pendWrite) begin
          hiReg <= pendHi;
          loReg <= pendLo;
        end
      end else begin
        if (writeHi) hiReg <= bus.rs_val;
        if (writeLo) loReg <= bus.rs_val;
      end
    end
  end

  assign bus.busy = (state == ST_BUSY);
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule
